// File: rtl/izh_pkg.sv
// Shared definitions for the Izhikevich neuron update datapath and its sequencer.
package izh_pkg;

  // 17-bit sign-magnitude fixed point: bit 16 sign, [15:8] integer, [7:0] fraction.
  localparam int FIX_W        = 17;
  localparam int FIX_SIGN_BIT = 16;

  typedef logic [FIX_W-1:0] fix_t;

  // Spike threshold, +30.0 in the fixed-point format above.
  localparam fix_t V_THRESH = 17'h01E00;

  // Sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

  // True when a fixed-point value carries a negative sign.
  function automatic logic fix_is_neg(input fix_t x);
    return x[FIX_SIGN_BIT];
  endfunction

endpackage

// File: rtl/neuron_update_sequencer_spike_fifo.sv
// Synchronous spike-index FIFO; exposes its fill count so the sequencer can
// reserve room for every result still travelling through the pipeline.
module spike_fifo
  import izh_pkg::*;
#(
  parameter  int DEPTH = 8,
  parameter  int WIDTH = 6,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] head_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             full;
  logic             do_push, do_pop;

  assign valid_o = (count_q != '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop_i && valid_o;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push_i && (!full || do_pop);
  assign head_o  = valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // Pointers and fill count.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // An overflowing push means the upstream credit check is broken.
  assert property (@(posedge clk_i) disable iff (rst_i) !(push_i && full && !do_pop))
    else $error("spike_fifo: push while full");

endmodule

// File: rtl/neuron_update_sequencer.sv
// Sweeps every neuron index once per timestep through the Izhikevich update
// pipeline, writes the updated state back and queues fired indices for routing.
//
//  state | meaning
//  IDLE  | waiting for start
//  SWEEP | issuing reads, one index per cycle while FIFO credit allows
//  DRAIN | all indices issued, waiting for the pipeline to empty
//  DONE  | one-cycle completion pulse
module neuron_update_sequencer
  import izh_pkg::*;
#(
  parameter int N_NEURONS  = 64,
  parameter int IDX_W      = 6,
  parameter int PIPE_LAT   = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [IDX_W:0]   spike_count_o,
  output logic             rd_en_o,
  output logic [IDX_W-1:0] rd_addr_o,
  input  logic [FIX_W-1:0] rd_v_i,
  input  logic [FIX_W-1:0] rd_u_i,
  input  logic [FIX_W-1:0] rd_i_i,
  input  logic [FIX_W-1:0] rd_a_i,
  input  logic [FIX_W-1:0] rd_b_i,
  input  logic [FIX_W-1:0] rd_c_i,
  input  logic [FIX_W-1:0] rd_d_i,
  output logic [FIX_W-1:0] pipe_v_o,
  output logic [FIX_W-1:0] pipe_u_o,
  output logic [FIX_W-1:0] pipe_i_o,
  output logic [FIX_W-1:0] pipe_a_o,
  output logic [FIX_W-1:0] pipe_b_o,
  output logic [FIX_W-1:0] pipe_c_o,
  output logic [FIX_W-1:0] pipe_d_o,
  input  logic [FIX_W-1:0] pipe_v_prime_i,
  input  logic [FIX_W-1:0] pipe_u_prime_i,
  input  logic             pipe_fired_i,
  output logic             wr_en_o,
  output logic [IDX_W-1:0] wr_addr_o,
  output logic [FIX_W-1:0] wr_v_o,
  output logic [FIX_W-1:0] wr_u_o,
  output logic             spk_valid_o,
  input  logic             spk_ready_i,
  output logic [IDX_W-1:0] spk_idx_o
);

  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int CRED_W = 16;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);

  seq_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W:0]   spk_cnt_q, spk_cnt_d;

  // Tracker: stage 0 holds the index whose read data is on the pipeline
  // inputs; stage PIPE_LAT holds the index whose result is on the outputs.
  logic [PIPE_LAT:0] trk_vld_q;
  logic [IDX_W-1:0]  trk_idx_q [PIPE_LAT+1];

  logic              issue;
  logic              accept_start;
  logic              exit_vld;
  logic              push;
  logic              trk_busy_after;
  logic [CNT_W-1:0]  fifo_count;
  logic [CRED_W-1:0] in_flight;
  logic [CRED_W-1:0] free_slots;
  logic              credit_ok;

  // Count results that are still going to land (each may need a FIFO slot).
  always_comb begin
    in_flight = '0;
    for (int k = 0; k <= PIPE_LAT; k++) begin
      in_flight = in_flight + CRED_W'(trk_vld_q[k]);
    end
  end

  assign free_slots = CRED_W'(FIFO_DEPTH) - CRED_W'(fifo_count);
  // Strictly greater: the new issue needs a slot on top of everything in flight.
  assign credit_ok  = (free_slots > in_flight);

  // Anything still in flight after the exiting stage moves out this cycle.
  assign trk_busy_after = |trk_vld_q[PIPE_LAT-1:0];

  assign accept_start = (state_q == ST_IDLE) && start_i && !rst_i;

  // Next-state, index counter and read issue.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    issue   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_SWEEP;
          idx_d   = '0;
        end
      end
      ST_SWEEP: begin
        if (credit_ok) begin
          issue = 1'b1;
          idx_d = idx_q + IDX_W'(1);
          if (idx_q == LAST_IDX) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (!trk_busy_after) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Saturating per-sweep spike counter.
  always_comb begin
    spk_cnt_d = spk_cnt_q;
    if (accept_start) begin
      spk_cnt_d = '0;
    end else if (push && (spk_cnt_q != '1)) begin
      spk_cnt_d = spk_cnt_q + (IDX_W+1)'(1);
    end
  end

  // FSM, index and spike counter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      spk_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      spk_cnt_q <= spk_cnt_d;
    end
  end

  // Tracker valid bits follow each issued read through the pipeline latency.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      trk_vld_q <= '0;
    end else begin
      trk_vld_q <= {trk_vld_q[PIPE_LAT-1:0], issue && !rst_i};
    end
  end

  // Tracker index bits shift alongside the valid bits.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k <= PIPE_LAT; k++) begin
        trk_idx_q[k] <= '0;
      end
    end else begin
      trk_idx_q[0] <= idx_q;
      for (int k = 1; k <= PIPE_LAT; k++) begin
        trk_idx_q[k] <= trk_idx_q[k-1];
      end
    end
  end

  // Results are only acted on when the tracker says a real neuron is exiting;
  // reset gates this so nothing in flight is written during the reset cycle.
  assign exit_vld = trk_vld_q[PIPE_LAT] && !rst_i;
  assign push     = exit_vld && pipe_fired_i;

  assign rd_en_o   = issue && !rst_i;
  assign rd_addr_o = rd_en_o ? idx_q : '0;

  assign pipe_v_o = rd_v_i;
  assign pipe_u_o = rd_u_i;
  assign pipe_i_o = rd_i_i;
  assign pipe_a_o = rd_a_i;
  assign pipe_b_o = rd_b_i;
  assign pipe_c_o = rd_c_i;
  assign pipe_d_o = rd_d_i;

  assign wr_en_o   = exit_vld;
  assign wr_addr_o = exit_vld ? trk_idx_q[PIPE_LAT] : '0;
  assign wr_v_o    = exit_vld ? pipe_v_prime_i : '0;
  assign wr_u_o    = exit_vld ? pipe_u_prime_i : '0;

  assign busy_o        = (state_q != ST_IDLE);
  assign done_o        = (state_q == ST_DONE);
  assign spike_count_o = spk_cnt_q;

  spike_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (IDX_W)
  ) u_spike_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (push),
    .push_data_i (trk_idx_q[PIPE_LAT]),
    .pop_i       (spk_ready_i),
    .valid_o     (spk_valid_o),
    .head_o      (spk_idx_o),
    .count_o     (fifo_count)
  );

endmodule
